// File: rtl/up_ctrl_pkg.sv
// Shared types and encodings for the UP multicycle control unit.
// States, ALU opcodes, instruction classes, RV64 opcodes/funct fields and datapath mux selects.
package up_ctrl_pkg;

    typedef enum logic [3:0] {
        RESET  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EX_R   = 4'd3,
        EX_I   = 4'd4,
        LUI    = 4'd5,
        ADDR   = 4'd6,
        MEM_LD = 4'd7,
        MEM_SD = 4'd8,
        WB_ALU = 4'd9,
        WB_LD  = 4'd10,
        BRANCH = 4'd11,
        PC_INC = 4'd12,
        HALT   = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASSA = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_PASSB = 3'b110,
        ALU_RSVD  = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LD   = 3'd2,
        CLS_SD   = 3'd3,
        CLS_BR   = 3'd4,
        CLS_LUI  = 3'd5,
        CLS_HALT = 3'd6
    } instr_class_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_SYS = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ebreak is imm=1 with rs1/funct3/rd all zero, i.e. bits [31:7] fixed.
    localparam logic [24:0] EBREAK_HI = 25'h0002000;

    localparam logic       MUX2_PC      = 1'b0;
    localparam logic       MUX2_REGA    = 1'b1;
    localparam logic [1:0] MUX4_REGB    = 2'd0;
    localparam logic [1:0] MUX4_FOUR    = 2'd1;
    localparam logic [1:0] MUX4_SIGN    = 2'd2;
    localparam logic [1:0] MUX4_SHIFT   = 2'd3;
    localparam logic       MUXMEM_ALU   = 1'b0;
    localparam logic       MUXMEM_MEM   = 1'b1;
    localparam logic       MUXPC_ALU    = 1'b0;
    localparam logic       MUXPC_ALUOUT = 1'b1;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: IR contents -> class, ALU opcode, beq/bne, illegal flag.
module instr_decoder
    import up_ctrl_pkg::*;
(
    input  logic [31:0]   instr_i,
    output instr_class_t  cls_o,
    output alu_op_t       alu_op_o,
    output logic          is_bne_o,
    output logic          illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    instr_class_t cls_raw;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        legal    = 1'b0;
        cls_raw  = CLS_HALT;
        alu_op_o = ALU_PASSA;
        is_bne_o = 1'b0;
        case (opcode)
            OPC_R: begin
                cls_raw = CLS_R;
                case (f3)
                    F3_ADD: begin
                        if (f7 == F7_BASE) begin
                            legal = 1'b1; alu_op_o = ALU_ADD;
                        end else if (f7 == F7_ALT) begin
                            legal = 1'b1; alu_op_o = ALU_SUB;
                        end
                    end
                    F3_AND: begin legal = (f7 == F7_BASE); alu_op_o = ALU_AND; end
                    F3_OR:  begin legal = (f7 == F7_BASE); alu_op_o = ALU_OR;  end
                    F3_XOR: begin legal = (f7 == F7_BASE); alu_op_o = ALU_XOR; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                cls_raw = CLS_I;
                case (f3)
                    F3_ADD: begin legal = 1'b1; alu_op_o = ALU_ADD; end
                    F3_AND: begin legal = 1'b1; alu_op_o = ALU_AND; end
                    F3_OR:  begin legal = 1'b1; alu_op_o = ALU_OR;  end
                    F3_XOR: begin legal = 1'b1; alu_op_o = ALU_XOR; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LD: begin
                cls_raw = CLS_LD;
                legal   = (f3 == F3_DW);
            end
            OPC_SD: begin
                cls_raw = CLS_SD;
                legal   = (f3 == F3_DW);
            end
            OPC_BR: begin
                cls_raw  = CLS_BR;
                legal    = (f3 == F3_BEQ) || (f3 == F3_BNE);
                is_bne_o = (f3 == F3_BNE);
            end
            OPC_LUI: begin
                cls_raw  = CLS_LUI;
                legal    = 1'b1;
                alu_op_o = ALU_PASSB;
            end
            OPC_SYS: begin
                cls_raw = CLS_HALT;
                legal   = (instr_i[31:7] == EBREAK_HI);
            end
            default: legal = 1'b0;
        endcase
        cls_o     = legal ? cls_raw : CLS_HALT;
        illegal_o = ~legal;
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle control FSM for the UP RISC-V datapath: fetch/decode/execute/memory/writeback sequencing.
// A shared wait counter stretches FETCH and MEM_LD to MEM_LAT cycles.
module control_unit_fsm
    import up_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i31_0,
    input  logic        AluZero,
    output logic        PCwrite,
    output logic        IRwrite,
    output logic        MemRead,
    output logic        MemData_Read,
    output logic        DMemWr,
    output logic        RegWrite,
    output logic        loadRegA,
    output logic        loadRegB,
    output logic        loadRegMemData,
    output logic        loadRegAluOut,
    output logic        SelMux2,
    output logic [1:0]  SelMux4,
    output logic        SelMuxMem,
    output logic        SelMuxPC,
    output logic [2:0]  AluOperation,
    output logic        exitState,
    output logic [3:0]  state_o
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_last;
    alu_op_t          alu_op;

    instr_class_t dec_cls;
    alu_op_t      dec_op;
    logic         dec_bne;
    logic         dec_illegal;

    instr_decoder u_dec (
        .instr_i   (i31_0),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_op),
        .is_bne_o  (dec_bne),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wait_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        PCwrite        = 1'b0;
        IRwrite        = 1'b0;
        MemRead        = 1'b0;
        MemData_Read   = 1'b0;
        DMemWr         = 1'b0;
        RegWrite       = 1'b0;
        loadRegA       = 1'b0;
        loadRegB       = 1'b0;
        loadRegMemData = 1'b0;
        loadRegAluOut  = 1'b0;
        SelMux2        = MUX2_PC;
        SelMux4        = MUX4_REGB;
        SelMuxMem      = MUXMEM_ALU;
        SelMuxPC       = MUXPC_ALU;
        alu_op         = ALU_PASSA;
        exitState      = 1'b0;

        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                if (wait_last) begin
                    IRwrite = 1'b1;
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                // Speculatively compute the branch target while the register file is read.
                loadRegA      = 1'b1;
                loadRegB      = 1'b1;
                SelMux4       = MUX4_SHIFT;
                alu_op        = ALU_ADD;
                loadRegAluOut = 1'b1;
                if (dec_illegal) begin
                    state_d = HALT;
                end else begin
                    case (dec_cls)
                        CLS_R:   state_d = EX_R;
                        CLS_I:   state_d = EX_I;
                        CLS_LD:  state_d = ADDR;
                        CLS_SD:  state_d = ADDR;
                        CLS_BR:  state_d = BRANCH;
                        CLS_LUI: state_d = LUI;
                        default: state_d = HALT;
                    endcase
                end
            end
            EX_R, EX_I: begin
                SelMux2       = MUX2_REGA;
                SelMux4       = (state_q == EX_I) ? MUX4_SIGN : MUX4_REGB;
                alu_op        = dec_op;
                loadRegAluOut = 1'b1;
                state_d       = WB_ALU;
            end
            LUI: begin
                SelMux4       = MUX4_SIGN;
                alu_op        = ALU_PASSB;
                loadRegAluOut = 1'b1;
                state_d       = WB_ALU;
            end
            ADDR: begin
                SelMux2       = MUX2_REGA;
                SelMux4       = MUX4_SIGN;
                alu_op        = ALU_ADD;
                loadRegAluOut = 1'b1;
                state_d       = (dec_cls == CLS_SD) ? MEM_SD : MEM_LD;
            end
            MEM_LD: begin
                MemData_Read = 1'b1;
                if (wait_last) begin
                    loadRegMemData = 1'b1;
                    state_d        = WB_LD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM_SD, WB_ALU, WB_LD, PC_INC: begin
                DMemWr    = (state_q == MEM_SD);
                RegWrite  = (state_q == WB_ALU) || (state_q == WB_LD);
                SelMuxMem = (state_q == WB_LD) ? MUXMEM_MEM : MUXMEM_ALU;
                SelMux4   = MUX4_FOUR;
                alu_op    = ALU_ADD;
                SelMuxPC  = MUXPC_ALU;
                PCwrite   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                SelMux2 = MUX2_REGA;
                SelMux4 = MUX4_REGB;
                alu_op  = ALU_SUB;
                if (dec_bne ? ~AluZero : AluZero) begin
                    PCwrite  = 1'b1;
                    SelMuxPC = MUXPC_ALUOUT;
                    state_d  = FETCH;
                end else begin
                    state_d = PC_INC;
                end
            end
            HALT: exitState = 1'b1;
            default: state_d = HALT;
        endcase
    end

    assign AluOperation = alu_op;
    assign state_o      = state_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: per-cycle vector table (MEM_LAT=2) plus hand sequences.
module tb_control_unit_fsm;
    import up_ctrl_pkg::*;

    localparam logic [18:0] M_PCW = 19'h40000, M_IRW = 19'h20000, M_MR  = 19'h10000;
    localparam logic [18:0] M_MDR = 19'h08000, M_DMW = 19'h04000, M_RW  = 19'h02000;
    localparam logic [18:0] M_LA  = 19'h01000, M_LB  = 19'h00800, M_LMD = 19'h00400;
    localparam logic [18:0] M_LAO = 19'h00200, M_S2  = 19'h00100, M_SMM = 19'h00020;
    localparam logic [18:0] M_SPC = 19'h00010, M_EX  = 19'h00001;
    localparam logic [18:0] S4_ONE = 19'd1 << 6, S4_SIGN = 19'd2 << 6, S4_SHIFT = 19'd3 << 6;
    localparam logic [18:0] A_ADD = 19'd1 << 1, A_SUB = 19'd2 << 1, A_AND = 19'd3 << 1;
    localparam logic [18:0] A_OR  = 19'd4 << 1, A_XOR = 19'd5 << 1, A_PASSB = 19'd6 << 1;

    localparam logic [18:0] O_DEC = M_LA | M_LB | M_LAO | S4_SHIFT | A_ADD;
    localparam logic [18:0] O_EXR = M_S2 | M_LAO;
    localparam logic [18:0] O_EXI = M_S2 | S4_SIGN | M_LAO;
    localparam logic [18:0] O_LUI = S4_SIGN | A_PASSB | M_LAO;
    localparam logic [18:0] O_ADR = M_S2 | S4_SIGN | A_ADD | M_LAO;
    localparam logic [18:0] O_PC4 = S4_ONE | A_ADD | M_PCW;
    localparam logic [18:0] O_WBA = M_RW | O_PC4;
    localparam logic [18:0] O_WBL = M_RW | M_SMM | O_PC4;
    localparam logic [18:0] O_MSD = M_DMW | O_PC4;
    localparam logic [18:0] O_BRT = M_S2 | A_SUB | M_PCW | M_SPC;
    localparam logic [18:0] O_BRN = M_S2 | A_SUB;

    localparam logic [31:0] I_ADDI = 32'h00700293, I_SUB  = 32'h402081B3, I_AND = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3, I_XOR  = 32'h0020C1B3, I_SLT = 32'h0020A1B3;
    localparam logic [31:0] I_XORI = 32'h0030C293, I_ANDI = 32'h0030F293, I_LD  = 32'h0080B303;
    localparam logic [31:0] I_SD   = 32'h0060B423, I_BEQ  = 32'h00208463, I_BNE = 32'h00209463;
    localparam logic [31:0] I_LUI  = 32'h123453B7, I_EBRK = 32'h00100073, I_FENCE = 32'h0000000F;

    logic        clk = 1'b0;
    logic        rst2, rst3, zero;
    logic [31:0] instr;
    wire  [18:0] o2, o3;
    wire  [3:0]  st2, st3;

    always #5 clk = ~clk;

    control_unit_fsm u_dut2 (
        .clk(clk), .rst(rst2), .i31_0(instr), .AluZero(zero),
        .PCwrite(o2[18]), .IRwrite(o2[17]), .MemRead(o2[16]), .MemData_Read(o2[15]),
        .DMemWr(o2[14]), .RegWrite(o2[13]), .loadRegA(o2[12]), .loadRegB(o2[11]),
        .loadRegMemData(o2[10]), .loadRegAluOut(o2[9]), .SelMux2(o2[8]), .SelMux4(o2[7:6]),
        .SelMuxMem(o2[5]), .SelMuxPC(o2[4]), .AluOperation(o2[3:1]), .exitState(o2[0]),
        .state_o(st2)
    );

    control_unit_fsm #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .i31_0(instr), .AluZero(zero),
        .PCwrite(o3[18]), .IRwrite(o3[17]), .MemRead(o3[16]), .MemData_Read(o3[15]),
        .DMemWr(o3[14]), .RegWrite(o3[13]), .loadRegA(o3[12]), .loadRegB(o3[11]),
        .loadRegMemData(o3[10]), .loadRegAluOut(o3[9]), .SelMux2(o3[8]), .SelMux4(o3[7:6]),
        .SelMuxMem(o3[5]), .SelMuxPC(o3[4]), .AluOperation(o3[3:1]), .exitState(o3[0]),
        .state_o(st3)
    );

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        state_t      st;
        logic [18:0] outs;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] i, input logic z,
                       input state_t s, input logic [18:0] o);
        vec_t v;
        v.rst = r; v.instr = i; v.zero = z; v.st = s; v.outs = o;
        tbl.push_back(v);
    endtask

    task automatic add_fd(input logic [31:0] i, input logic z);
        add(1'b1, i, z, FETCH, M_MR);
        add(1'b1, i, z, FETCH, M_MR | M_IRW);
        add(1'b1, i, z, DECODE, O_DEC);
    endtask

    task automatic add_alu(input logic [31:0] i, input state_t ex, input logic [18:0] exo);
        add_fd(i, 1'b0);
        add(1'b1, i, 1'b0, ex, exo);
        add(1'b1, i, 1'b0, WB_ALU, O_WBA);
    endtask

    initial begin
        vec_t v, e;
        int   mdr, len, dmw, n;
        bit   done;

        add(1'b0, 32'h0, 1'b0, RESET, 19'h0);
        add(1'b1, I_ADDI, 1'b0, RESET, 19'h0);
        add_alu(I_ADDI, EX_I, O_EXI | A_ADD);
        add_alu(I_SUB,  EX_R, O_EXR | A_SUB);
        add_alu(I_AND,  EX_R, O_EXR | A_AND);
        add_alu(I_OR,   EX_R, O_EXR | A_OR);
        add_alu(I_XOR,  EX_R, O_EXR | A_XOR);
        add_alu(I_XORI, EX_I, O_EXI | A_XOR);
        add_alu(I_ANDI, EX_I, O_EXI | A_AND);
        add_alu(I_LUI,  LUI,  O_LUI);
        add_fd(I_LD, 1'b0);
        add(1'b1, I_LD, 1'b0, ADDR, O_ADR);
        add(1'b1, I_LD, 1'b0, MEM_LD, M_MDR);
        add(1'b1, I_LD, 1'b0, MEM_LD, M_MDR | M_LMD);
        add(1'b1, I_LD, 1'b0, WB_LD, O_WBL);
        add_fd(I_SD, 1'b0);
        add(1'b1, I_SD, 1'b0, ADDR, O_ADR);
        add(1'b1, I_SD, 1'b0, MEM_SD, O_MSD);
        add_fd(I_BEQ, 1'b1);
        add(1'b1, I_BEQ, 1'b1, BRANCH, O_BRT);
        add_fd(I_BEQ, 1'b0);
        add(1'b1, I_BEQ, 1'b0, BRANCH, O_BRN);
        add(1'b1, I_BEQ, 1'b0, PC_INC, O_PC4);
        add_fd(I_BNE, 1'b0);
        add(1'b1, I_BNE, 1'b0, BRANCH, O_BRT);
        add_fd(I_BNE, 1'b1);
        add(1'b1, I_BNE, 1'b1, BRANCH, O_BRN);
        add(1'b1, I_BNE, 1'b1, PC_INC, O_PC4);
        // Reset arriving mid-load: the access is abandoned with no writeback.
        add_fd(I_LD, 1'b0);
        add(1'b1, I_LD, 1'b0, ADDR, O_ADR);
        add(1'b0, I_LD, 1'b0, MEM_LD, M_MDR);
        add(1'b0, I_LD, 1'b0, RESET, 19'h0);
        add(1'b1, I_LD, 1'b0, RESET, 19'h0);
        add(1'b0, I_ADDI, 1'b0, FETCH, M_MR);
        add(1'b1, I_ADDI, 1'b0, RESET, 19'h0);
        add_fd(I_SLT, 1'b0);
        add(1'b1, I_SLT, 1'b0, HALT, M_EX);
        add(1'b1, I_SLT, 1'b0, HALT, M_EX);
        add(1'b0, I_SLT, 1'b0, HALT, M_EX);
        add(1'b1, I_FENCE, 1'b0, RESET, 19'h0);
        add_fd(I_FENCE, 1'b0);
        add(1'b1, I_FENCE, 1'b0, HALT, M_EX);
        add(1'b0, I_FENCE, 1'b0, HALT, M_EX);
        add(1'b1, I_FENCE, 1'b0, RESET, 19'h0);

        rst2 = 1'b0; rst3 = 1'b0; zero = 1'b0; instr = 32'h0;
        repeat (2) @(negedge clk);

        foreach (tbl[k]) begin
            v = tbl[k];
            rst2 = v.rst; instr = v.instr; zero = v.zero;
            exp_q.push_back(v);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("step%0d_state", k), 32'(st2), 32'(e.st));
            chk($sformatf("step%0d_outs", k), 32'(o2), 32'(e.outs));
            @(negedge clk);
        end

        // ld on the MEM_LAT=3 instance
        rst2 = 1'b0; instr = I_LD; zero = 1'b0; rst3 = 1'b1;
        #1;
        chk("ld3_start_reset", 32'(st3), 32'(RESET));
        mdr = 0; len = 0; done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk); #1;
            len++;
            if (o3[15]) begin
                mdr++;
                chk($sformatf("ld3_lmd_cyc%0d", mdr), 32'(o3[10]), 32'(mdr == 3));
            end
            if (st3 == WB_LD) begin
                done = 1'b1;
                chk("ld3_wb_outs", 32'(o3), 32'(O_WBL));
            end
        end
        chk("ld3_reached_wb", 32'(done), 32'd1);
        chk("ld3_mdr_cycles", 32'(mdr), 32'd3);
        chk("ld3_total_cycles", 32'(len), 32'd9);
        @(negedge clk);
        rst3 = 1'b0;

        // sd followed by ebreak, then HALT held until reset
        rst2 = 1'b1; instr = I_SD;
        #1;
        dmw = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (o2[14]) dmw++;
            if (st2 == MEM_SD) instr = I_EBRK;
            if (st2 == HALT) done = 1'b1;
            else begin
                @(negedge clk); #1;
            end
        end
        chk("sd_ebreak_reached_halt", 32'(done), 32'd1);
        chk("sd_dmemwr_pulses", 32'(dmw), 32'd1);
        n = 0;
        repeat (20) begin
            @(negedge clk); #1;
            n++;
            chk($sformatf("halt_hold%0d", n), 32'(o2), 32'(M_EX));
        end
        rst2 = 1'b0;
        @(negedge clk); #1;
        chk("halt_reset_state", 32'(st2), 32'(RESET));
        chk("halt_reset_outs", 32'(o2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
